// File: rtl/viterbi_pmu_pkg.sv
// viterbi_pmu_pkg: shared defaults, codeword index encoding and encoder helper for the path-metric unit.
// Optional feature macro used by viterbi_pmu: ACS_BEST_EN (registered minimum-metric search).
package viterbi_pmu_pkg;

  localparam int         K_DEF  = 7;
  localparam logic [6:0] G0_DEF = 7'o133;
  localparam logic [6:0] G1_DEF = 7'o171;

  // Codeword {c1,c0} doubles as the slice index into di_bm.
  typedef enum logic [1:0] {
    CW_00 = 2'd0,
    CW_01 = 2'd1,
    CW_10 = 2'd2,
    CW_11 = 2'd3
  } cw_e;

  function automatic cw_e acs_codeword(input logic [31:0] g0, input logic [31:0] g1,
                                       input logic [31:0] enc);
    return cw_e'({^(g1 & enc), ^(g0 & enc)});
  endfunction

endpackage

// File: rtl/viterbi_pmu_acs_butterfly.sv
// viterbi_pmu_acs_butterfly: combinational radix-2 ACS, preds 2i/2i+1 into states i and i+NS/2.
// Saturating adds; a tie keeps the even predecessor (survivor bit 0).
module viterbi_pmu_acs_butterfly #(
  parameter int BM_W = 2,
  parameter int PM_W = 12
) (
  input  logic [PM_W-1:0] pm_p0,
  input  logic [PM_W-1:0] pm_p1,
  input  logic [BM_W-1:0] bm_lo_p0,
  input  logic [BM_W-1:0] bm_lo_p1,
  input  logic [BM_W-1:0] bm_hi_p0,
  input  logic [BM_W-1:0] bm_hi_p1,
  output logic [PM_W-1:0] new_lo,
  output logic [PM_W-1:0] new_hi,
  output logic            sur_lo,
  output logic            sur_hi
);

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [BM_W-1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W + 1 - BM_W){1'b0}}, b};
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  logic [PM_W-1:0] c_lo0, c_lo1, c_hi0, c_hi1;

  always_comb begin
    c_lo0  = sat_add(pm_p0, bm_lo_p0);
    c_lo1  = sat_add(pm_p1, bm_lo_p1);
    c_hi0  = sat_add(pm_p0, bm_hi_p0);
    c_hi1  = sat_add(pm_p1, bm_hi_p1);
    sur_lo = (c_lo1 < c_lo0);
    sur_hi = (c_hi1 < c_hi0);
    new_lo = sur_lo ? c_lo1 : c_lo0;
    new_hi = sur_hi ? c_hi1 : c_hi0;
  end

endmodule

// File: rtl/viterbi_pmu.sv
// viterbi_pmu: registered path-metric unit, NS/2 ACS butterflies per trellis step, MSB normalisation.
// Define ACS_BEST_EN to add the registered min search on do_best_state/do_best_pm (else tied 0).
module viterbi_pmu
  import viterbi_pmu_pkg::*;
#(
  parameter int           K    = K_DEF,
  parameter int           BM_W = 2,
  parameter int           PM_W = 12,
  parameter logic [K-1:0] G0   = G0_DEF,
  parameter logic [K-1:0] G1   = G1_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    di_vld,
  input  logic                    di_sof,
  input  logic [4*BM_W-1:0]       di_bm,
  output logic                    do_vld,
  output logic [(1<<(K-1))-1:0]   do_sur,
  output logic                    do_norm,
  output logic [K-2:0]            do_best_state,
  output logic [PM_W-1:0]         do_best_pm
);

  localparam int NS   = 1 << (K - 1);
  localparam int HALF = NS / 2;
  localparam logic [PM_W-1:0] INIT_PM = {2'b01, {(PM_W - 2){1'b0}}};

  function automatic logic [PM_W-1:0] init_pm(input int j);
    return (j == 0) ? '0 : INIT_PM;
  endfunction

  logic [PM_W-1:0] pm_q     [NS];
  logic [PM_W-1:0] pm_d     [NS];
  logic [PM_W-1:0] base     [NS];
  logic [PM_W-1:0] acs_new  [NS];
  logic [PM_W-1:0] acs_norm [NS];
  logic [NS-1:0]   acs_sur;
  logic            all_msb;

  logic            do_vld_q, do_vld_d;
  logic            do_norm_q, do_norm_d;
  logic [NS-1:0]   do_sur_q, do_sur_d;

  always_comb begin
    for (int j = 0; j < NS; j++) base[j] = di_sof ? init_pm(j) : pm_q[j];
  end

  // Codewords are fixed by G0/G1, so each butterfly gets only the four metrics it needs.
  for (genvar i = 0; i < HALF; i++) begin : g_bfly
    localparam int  ENC_L0 = 2 * i;
    localparam int  ENC_L1 = 2 * i + 1;
    localparam int  ENC_H0 = ENC_L0 + (1 << (K - 1));
    localparam int  ENC_H1 = ENC_L1 + (1 << (K - 1));
    localparam cw_e CW_L0  = acs_codeword(32'(G0), 32'(G1), 32'(ENC_L0));
    localparam cw_e CW_L1  = acs_codeword(32'(G0), 32'(G1), 32'(ENC_L1));
    localparam cw_e CW_H0  = acs_codeword(32'(G0), 32'(G1), 32'(ENC_H0));
    localparam cw_e CW_H1  = acs_codeword(32'(G0), 32'(G1), 32'(ENC_H1));

    viterbi_pmu_acs_butterfly #(
      .BM_W (BM_W),
      .PM_W (PM_W)
    ) u_bfly (
      .pm_p0    (base[2*i]),
      .pm_p1    (base[2*i+1]),
      .bm_lo_p0 (di_bm[int'(CW_L0)*BM_W +: BM_W]),
      .bm_lo_p1 (di_bm[int'(CW_L1)*BM_W +: BM_W]),
      .bm_hi_p0 (di_bm[int'(CW_H0)*BM_W +: BM_W]),
      .bm_hi_p1 (di_bm[int'(CW_H1)*BM_W +: BM_W]),
      .new_lo   (acs_new[i]),
      .new_hi   (acs_new[i+HALF]),
      .sur_lo   (acs_sur[i]),
      .sur_hi   (acs_sur[i+HALF])
    );
  end

  always_comb begin
    all_msb = 1'b1;
    for (int j = 0; j < NS; j++) all_msb = all_msb & acs_new[j][PM_W-1];
    for (int j = 0; j < NS; j++) begin
      acs_norm[j] = acs_new[j];
      if (all_msb) acs_norm[j][PM_W-1] = 1'b0;
    end
  end

  always_comb begin
    for (int j = 0; j < NS; j++) pm_d[j] = pm_q[j];
    if (di_vld) begin
      for (int j = 0; j < NS; j++) pm_d[j] = acs_norm[j];
    end else if (di_sof) begin
      for (int j = 0; j < NS; j++) pm_d[j] = init_pm(j);
    end
    do_vld_d  = di_vld;
    do_norm_d = di_vld & all_msb;
    do_sur_d  = di_vld ? acs_sur : do_sur_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NS; j++) pm_q[j] <= init_pm(j);
      do_vld_q  <= 1'b0;
      do_norm_q <= 1'b0;
      do_sur_q  <= '0;
    end else begin
      for (int j = 0; j < NS; j++) pm_q[j] <= pm_d[j];
      do_vld_q  <= do_vld_d;
      do_norm_q <= do_norm_d;
      do_sur_q  <= do_sur_d;
    end
  end

  assign do_vld  = do_vld_q;
  assign do_norm = do_norm_q;
  assign do_sur  = do_sur_q;

`ifdef ACS_BEST_EN
  logic [K-2:0]    best_state_q, best_state_d, min_state;
  logic [PM_W-1:0] best_pm_q, best_pm_d, min_pm;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_state = '0;
    min_pm    = acs_norm[0];
    for (int j = 1; j < NS; j++) begin
      if (acs_norm[j] < min_pm) begin
        min_pm    = acs_norm[j];
        min_state = (K-1)'(j);
      end
    end
    best_state_d = di_vld ? min_state : best_state_q;
    best_pm_d    = di_vld ? min_pm : best_pm_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_state_q <= '0;
      best_pm_q    <= '0;
    end else begin
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
    end
  end

  assign do_best_state = best_state_q;
  assign do_best_pm    = best_pm_q;
`else
  assign do_best_state = '0;
  assign do_best_pm    = '0;
`endif

endmodule

// File: tb/tb_viterbi_pmu.sv
// tb_viterbi_pmu: two instances (PM_W=12 and PM_W=6) on shared stimulus, checked against a
// per-state trellis reference model, a vector table, and directed normalisation/encoder/reset sequences.
module tb_viterbi_pmu;

  localparam int K  = 7;
  localparam int NS = 64;
  localparam int G0 = 'o133;
  localparam int G1 = 'o171;
`ifdef ACS_BEST_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        di_vld = 1'b0;
  logic        di_sof = 1'b0;
  logic [7:0]  di_bm = 8'h00;

  logic        a_vld, a_norm, b_vld, b_norm;
  logic [63:0] a_sur, b_sur;
  logic [5:0]  a_bs, b_bs;
  logic [11:0] a_bp;
  logic [5:0]  b_bp;

  always #5 clk = ~clk;

  viterbi_pmu #(.K(7), .BM_W(2), .PM_W(12)) dut_a (
    .clk(clk), .rst(rst), .di_vld(di_vld), .di_sof(di_sof), .di_bm(di_bm),
    .do_vld(a_vld), .do_sur(a_sur), .do_norm(a_norm), .do_best_state(a_bs), .do_best_pm(a_bp)
  );

  viterbi_pmu #(.K(7), .BM_W(2), .PM_W(6)) dut_b (
    .clk(clk), .rst(rst), .di_vld(di_vld), .di_sof(di_sof), .di_bm(di_bm),
    .do_vld(b_vld), .do_sur(b_sur), .do_norm(b_norm), .do_best_state(b_bs), .do_best_pm(b_bp)
  );

  int          checks = 0;
  int          errors = 0;
  int          pw_of [2];
  int          ref_pm [2][NS];
  bit          ref_vld [2];
  bit          ref_norm [2];
  logic [63:0] ref_sur [2];
  int          ref_bs [2];
  int          ref_bp [2];
  int          enc_bits [6];

  typedef struct {
    bit          sof;
    bit          vld;
    logic [7:0]  bm;
    bit          e_vld;
    logic [63:0] sur_mask;
    logic [63:0] sur_val;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int par(input int v);
    return $countones(v) % 2;
  endfunction

  function automatic logic [7:0] hd_bm(input int rx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*2 +: 2] = 2'($countones(i ^ rx));
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < NS; j++) ref_pm[d][j] = (j == 0) ? 0 : (1 << (pw_of[d] - 2));
      ref_vld[d] = 0; ref_norm[d] = 0; ref_sur[d] = '0; ref_bs[d] = 0; ref_bp[d] = 0;
    end
  endtask

  // Trellis step from the state-transition rules: state j, input u = MSB, preds p = (2j mod NS)+b.
  task automatic model_step(input int d, input bit sof, input bit vld, input logic [7:0] bm);
    int pw, maxv, half, init, u, p, enc, cw, bi;
    int base [NS];
    int nw [NS];
    int cand [2];
    bit all;
    logic [63:0] s;
    pw = pw_of[d]; maxv = (1 << pw) - 1; half = 1 << (pw - 1); init = 1 << (pw - 2);
    if (!vld) begin
      if (sof) for (int j = 0; j < NS; j++) ref_pm[d][j] = (j == 0) ? 0 : init;
      ref_vld[d] = 0; ref_norm[d] = 0;
      return;
    end
    for (int j = 0; j < NS; j++) base[j] = sof ? ((j == 0) ? 0 : init) : ref_pm[d][j];
    all = 1; s = '0;
    for (int j = 0; j < NS; j++) begin
      u = j / (NS / 2);
      for (int b = 0; b < 2; b++) begin
        p = ((j * 2) % NS) + b;
        enc = u * (1 << (K - 1)) + p;
        cw = 2 * par(G1 & enc) + par(G0 & enc);
        cand[b] = base[p] + int'(bm[cw*2 +: 2]);
        if (cand[b] > maxv) cand[b] = maxv;
      end
      s[j] = (cand[1] < cand[0]);
      nw[j] = s[j] ? cand[1] : cand[0];
      if (nw[j] < half) all = 0;
    end
    bi = 0;
    for (int j = 0; j < NS; j++) begin
      if (all) nw[j] = nw[j] - half;
      ref_pm[d][j] = nw[j];
      if (nw[j] < nw[bi]) bi = j;
    end
    ref_vld[d] = 1; ref_norm[d] = all; ref_sur[d] = s; ref_bs[d] = bi; ref_bp[d] = nw[bi];
  endtask

  task automatic check_all();
    chk("a_vld",  64'(a_vld),  64'(ref_vld[0]));
    chk("a_sur",  a_sur,       ref_sur[0]);
    chk("a_norm", 64'(a_norm), 64'(ref_norm[0]));
    chk("a_best_state", 64'(a_bs), BEST_ON ? 64'(ref_bs[0]) : 64'd0);
    chk("a_best_pm",    64'(a_bp), BEST_ON ? 64'(ref_bp[0]) : 64'd0);
    chk("b_vld",  64'(b_vld),  64'(ref_vld[1]));
    chk("b_sur",  b_sur,       ref_sur[1]);
    chk("b_norm", 64'(b_norm), 64'(ref_norm[1]));
    chk("b_best_state", 64'(b_bs), BEST_ON ? 64'(ref_bs[1]) : 64'd0);
    chk("b_best_pm",    64'(b_bp), BEST_ON ? 64'(ref_bp[1]) : 64'd0);
  endtask

  task automatic cyc(input bit s, input bit v, input logic [7:0] b);
    di_sof = s; di_vld = v; di_bm = b;
    @(posedge clk);
    #1;
    model_step(0, s, v, b);
    model_step(1, s, v, b);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Noise-free frame of enc_bits; best state must track the encoder state at zero metric.
  task automatic encode_run(input int gap, input int nsteps);
    int s, u, enc, rx;
    s = 0;
    for (int i = 0; i < nsteps; i++) begin
      u = enc_bits[i];
      enc = (u << (K - 1)) | s;
      rx = 2 * par(G1 & enc) + par(G0 & enc);
      s = (u << (K - 2)) | (s >> 1);
      cyc(i == 0, 1'b1, hd_bm(rx));
      chk("enc_best_state", 64'(a_bs), BEST_ON ? 64'(s) : 64'd0);
      chk("enc_best_pm", 64'(a_bp), 64'd0);
      if (i < nsteps - 1) begin
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'b0, 8'h00);
          chk("gap_vld", 64'(a_vld), 64'd0);
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    pw_of[0] = 12; pw_of[1] = 6;
    enc_bits[0] = 1; enc_bits[1] = 0; enc_bits[2] = 1;
    enc_bits[3] = 1; enc_bits[4] = 0; enc_bits[5] = 0;

    // Codeword 00 costs 0: state 0 stays on its even predecessor for the whole frame.
    for (int i = 0; i < 20; i++) begin
      v.sof = (i == 0); v.vld = 1'b1; v.bm = {2'd2, 2'd1, 2'd1, 2'd0};
      v.e_vld = 1'b1; v.sur_mask = 64'h1; v.sur_val = 64'h0;
      tbl.push_back(v);
    end
    // All-zero metrics: every compare ties, survivors all 0; idle rows hold them.
    for (int i = 0; i < 10; i++) begin
      v.sof = (i == 0); v.vld = 1'b1; v.bm = 8'h00;
      v.e_vld = 1'b1; v.sur_mask = '1; v.sur_val = 64'h0;
      tbl.push_back(v);
    end
    for (int i = 0; i < 2; i++) begin
      v.sof = 1'b0; v.vld = 1'b0; v.bm = 8'hFF;
      v.e_vld = 1'b0; v.sur_mask = '1; v.sur_val = 64'h0;
      tbl.push_back(v);
    end

    #2;
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].sof, tbl[i].vld, tbl[i].bm);
      chk("tbl_vld",  64'(a_vld), 64'(tbl[i].e_vld));
      chk("tbl_sur",  a_sur & tbl[i].sur_mask, tbl[i].sur_val);
      chk("tbl_norm", 64'(a_norm), 64'd0);
    end

    // Uniform cost 2: min metric is 2n, so the 6-bit unit normalises at steps 16 and 32 only.
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      cyc(n == 1, 1'b1, 8'hAA);
      chk("norm6_step", 64'(b_norm), 64'((n == 16) || (n == 32)));
      chk("norm12_step", 64'(a_norm), 64'd0);
    end

    do_reset();
    encode_run(0, 6);
    do_reset();
    encode_run(3, 6);

    // Asynchronous reset in the middle of a frame.
    encode_run(0, 3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_vld", 64'(a_vld), 64'd0);
    chk("async_rst_sur", a_sur, 64'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    encode_run(0, 6);

    // sof with vld low, then a plain step from the reloaded pattern.
    cyc(1'b0, 1'b1, 8'h1B);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h6C);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
